// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-rate divider, horizontal/vertical counters and a
// registered colour/sync/blank output stage that trails x/y by one pixel.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    input  logic [7:0] R_in,
    input  logic [7:0] G_in,
    input  logic [7:0] B_in,
    output logic [7:0] vga_R,
    output logic [7:0] vga_G,
    output logic [7:0] vga_B,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk,
    output logic       frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] D_HALF   = DW'(CLK_DIV / 2);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] d_reg, d_next;
    logic [9:0]    h_reg, h_next;
    logic [9:0]    v_reg, v_next;
    logic          pe, active, hs_act, vs_act, frame_end;
    logic [23:0]   rgb_in, rgb_gated, rgb_reg;
    logic          hs_reg, vs_reg, blank_n_reg, vga_clk_reg, frame_tick_reg;

    always_comb begin
        pe     = (d_reg == D_LAST);
        d_next = pe ? '0 : d_reg + DW'(1);
        h_next = h_reg;
        v_next = v_reg;
        if (pe) begin
            if (h_reg == H_LAST) begin
                h_next = '0;
                v_next = (v_reg == V_LAST) ? '0 : v_reg + 10'd1;
            end else begin
                h_next = h_reg + 10'd1;
            end
        end
        active    = (h_reg < H_ACT) && (v_reg < V_ACT);
        hs_act    = (h_reg >= HS_FIRST) && (h_reg <= HS_LAST);
        vs_act    = (v_reg >= VS_FIRST) && (v_reg <= VS_LAST);
        frame_end = pe && (h_reg == H_LAST) && (v_reg == V_LAST);
    end

    // Colour is forced to black outside the visible area, per channel.
    assign rgb_in = {R_in, G_in, B_in};
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign rgb_gated[gi*8 +: 8] = active ? rgb_in[gi*8 +: 8] : 8'd0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg          <= '0;
            h_reg          <= '0;
            v_reg          <= '0;
            vga_clk_reg    <= 1'b0;
            rgb_reg        <= '0;
            hs_reg         <= 1'b1;
            vs_reg         <= 1'b1;
            blank_n_reg    <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            d_reg          <= d_next;
            h_reg          <= h_next;
            v_reg          <= v_next;
            // Tracks the divider phase so the DAC clock rises mid-pixel.
            vga_clk_reg    <= (d_next >= D_HALF);
            frame_tick_reg <= frame_end;
            if (pe) begin
                rgb_reg     <= rgb_gated;
                hs_reg      <= ~hs_act;
                vs_reg      <= ~vs_act;
                blank_n_reg <= active;
            end
        end
    end

    assign x           = h_reg;
    assign y           = v_reg;
    assign vga_R       = rgb_reg[23:16];
    assign vga_G       = rgb_reg[15:8];
    assign vga_B       = rgb_reg[7:0];
    assign vga_hs      = hs_reg;
    assign vga_vs      = vs_reg;
    assign vga_blank_n = blank_n_reg;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = vga_clk_reg;
    assign frame_tick  = frame_tick_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: two shrunken rasters (divide-by-2 and
// divide-by-4) checked every clock against an arithmetic raster model.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 13
    localparam int FR = HT * VT;             // 312 pixels per frame

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] g_in  = 8'd0;
    logic [7:0] b_in  = 8'd0;

    logic [9:0] x2, y2, x4, y4;
    logic [7:0] r2, gg2, bb2, r4, gg4, bb4;
    logic       hs2, vs2, bl2, sn2, vc2, ft2;
    logic       hs4, vs4, bl4, sn4, vc4, ft4;

    int          tests = 0;
    int          fails = 0;
    int          t     = 0;
    logic [23:0] cap2  = '0;
    logic [23:0] cap4  = '0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .x(x2), .y(y2),
        .R_in(x2[7:0]), .G_in(g_in), .B_in(b_in),
        .vga_R(r2), .vga_G(gg2), .vga_B(bb2),
        .vga_hs(hs2), .vga_vs(vs2), .vga_blank_n(bl2), .vga_sync_n(sn2),
        .vga_clk(vc2), .frame_tick(ft2)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .x(x4), .y(y4),
        .R_in(x4[7:0]), .G_in(g_in), .B_in(b_in),
        .vga_R(r4), .vga_G(gg4), .vga_B(bb4),
        .vga_hs(hs4), .vga_vs(vs4), .vga_blank_n(bl4), .vga_sync_n(sn4),
        .vga_clk(vc4), .frame_tick(ft4)
    );

    function automatic int hp(int p);
        return p % HT;
    endfunction

    function automatic int vp(int p);
        return (p / HT) % VT;
    endfunction

    function automatic logic [23:0] expcol(int p, logic [7:0] g, logic [7:0] b);
        int h;
        int v;
        h = hp(p);
        v = vp(p);
        if (h < HA && v < VA) return {8'(h), g, b};
        return 24'd0;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", nm, act, exp, t);
        end
    endtask

    task automatic check_dut(input string tag, input int n,
                             input logic [9:0] xx, input logic [9:0] yy,
                             input logic [7:0] rr, input logic [7:0] gg,
                             input logic [7:0] bb, input logic hs,
                             input logic vs, input logic bl, input logic sn,
                             input logic vc, input logic ft,
                             input logic [23:0] cap);
        int p;
        int eh;
        int ev;
        if (!rst_n) begin
            check({tag, ".rst_x"}, int'(xx), 0);
            check({tag, ".rst_y"}, int'(yy), 0);
            check({tag, ".rst_rgb"}, int'({rr, gg, bb}), 0);
            check({tag, ".rst_hs"}, int'(hs), 1);
            check({tag, ".rst_vs"}, int'(vs), 1);
            check({tag, ".rst_blank_n"}, int'(bl), 0);
            check({tag, ".rst_vga_clk"}, int'(vc), 0);
            check({tag, ".rst_frame_tick"}, int'(ft), 0);
            check({tag, ".rst_sync_n"}, int'(sn), 0);
        end else begin
            // p = pixel enables seen since reset release
            p = t / n;
            check({tag, ".x"}, int'(xx), hp(p));
            check({tag, ".y"}, int'(yy), vp(p));
            check({tag, ".vga_clk"}, int'(vc), int'((t % n) >= n / 2));
            check({tag, ".sync_n"}, int'(sn), 0);
            check({tag, ".frame_tick"}, int'(ft),
                  int'(t > 0 && (t % n) == 0 && (p % FR) == 0));
            if (p == 0) begin
                check({tag, ".hs"}, int'(hs), 1);
                check({tag, ".vs"}, int'(vs), 1);
                check({tag, ".blank_n"}, int'(bl), 0);
            end else begin
                eh = hp(p - 1);
                ev = vp(p - 1);
                check({tag, ".hs"}, int'(hs), int'(!(eh >= HA + HF && eh < HA + HF + HS)));
                check({tag, ".vs"}, int'(vs), int'(!(ev >= VA + VF && ev < VA + VF + VS)));
                check({tag, ".blank_n"}, int'(bl), int'(eh < HA && ev < VA));
            end
            check({tag, ".rgb"}, int'({rr, gg, bb}), int'(cap));
        end
    endtask

    // Reference raster: clock count since release, plus colour captured at each pixel enable.
    always @(posedge clk) begin
        if (!rst_n) begin
            t    <= 0;
            cap2 <= '0;
            cap4 <= '0;
        end else begin
            t <= t + 1;
            if (t % 2 == 1) cap2 <= expcol(t / 2, g_in, b_in);
            if (t % 4 == 3) cap4 <= expcol(t / 4, g_in, b_in);
        end
    end

    // Per-cycle compare plus literal timing pins for the shrunken raster.
    initial begin
        bit seen_hs2, seen_hs4, seen_ft2, seen_ft4, vs2_low;
        int vs2_fall;
        seen_hs2 = 0; seen_hs4 = 0; seen_ft2 = 0; seen_ft4 = 0; vs2_low = 0;
        vs2_fall = 0;
        forever begin
            @(negedge clk);
            check_dut("d2", 2, x2, y2, r2, gg2, bb2, hs2, vs2, bl2, sn2, vc2, ft2, cap2);
            check_dut("d4", 4, x4, y4, r4, gg4, bb4, hs4, vs4, bl4, sn4, vc4, ft4, cap4);
            if (!rst_n) begin
                seen_hs2 = 0; seen_hs4 = 0; seen_ft2 = 0; seen_ft4 = 0; vs2_low = 0;
            end else begin
                if (!seen_hs2 && !hs2) begin
                    seen_hs2 = 1;
                    check("d2.first_hs_fall", t, 38);
                end
                if (!seen_hs4 && !hs4) begin
                    seen_hs4 = 1;
                    check("d4.first_hs_fall", t, 76);
                end
                if (!seen_ft2 && ft2) begin
                    seen_ft2 = 1;
                    check("d2.first_frame_tick", t, 624);
                end
                if (!seen_ft4 && ft4) begin
                    seen_ft4 = 1;
                    check("d4.first_frame_tick", t, 1248);
                end
                if (!vs2 && !vs2_low) begin
                    vs2_low  = 1;
                    vs2_fall = t;
                    check("d2.vs_fall_phase", (t - 434) % 624, 0);
                end else if (vs2 && vs2_low) begin
                    vs2_low = 0;
                    check("d2.vs_low_clks", t - vs2_fall, 96);
                end
            end
        end
    end

    task automatic drive();
        @(negedge clk);
        #1;
        g_in = 8'($urandom);
        b_in = 8'($urandom);
    endtask

    initial begin
        int wait_n;
        #1 rst_n = 1'b0;
        repeat (4) drive();
        @(negedge clk);
        #1 rst_n = 1'b1;
        $display("[TB] reset released, running free");
        repeat (1900) drive();
        for (int k = 0; k < 3; k++) begin
            wait_n = $urandom_range(300, 1300);
            repeat (wait_n) drive();
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            check_dut("d2.async", 2, x2, y2, r2, gg2, bb2, hs2, vs2, bl2, sn2, vc2, ft2, cap2);
            check_dut("d4.async", 4, x4, y4, r4, gg4, bb4, hs4, vs4, bl4, sn4, vc4, ft4, cap4);
            $display("[TB] mid-frame reset %0d after %0d clks", k, wait_n);
            repeat (3) drive();
            @(negedge clk);
            #1 rst_n = 1'b1;
        end
        repeat (2600) drive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
